// File: rtl/crazy_elevator_ctrl.sv
// rtl/crazy_elevator_ctrl.sv - four-floor elevator controller
// Collects floor calls into a pending vector and services them with a direction-preferring FSM.
module crazy_elevator_ctrl #(
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES   = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] call_req,
   output logic [1:0] floor,
   output logic       motor_up,
   output logic       motor_down,
   output logic       door_open,
   output logic [3:0] pending,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MOVE_UP   = 2'd1,
      S_MOVE_DOWN = 2'd2,
      S_DOOR      = 2'd3
   } state_t;

   state_t      state_q, state_d, sel_state;
   logic [1:0]  floor_q, floor_d, floor_up, floor_dn;
   logic [3:0]  pending_q, pending_d, drop_mask, clr_mask;
   logic [15:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;
   logic        above, below, arrive, travel_done, door_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         floor_q   <= 2'd0;
         pending_q <= 4'b0000;
         dir_q     <= 1'b1;
         cnt_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      above       = 1'b0;
      below       = 1'b0;
      state_d     = state_q;
      floor_d     = floor_q;
      arrive      = 1'b0;
      floor_up    = floor_q + 2'd1;
      floor_dn    = floor_q - 2'd1;
      travel_done = (cnt_q == 16'(TRAVEL_CYCLES - 1));
      door_done   = (cnt_q == 16'(DOOR_CYCLES - 1));

      for (int i = 0; i < 4; i++) begin
         if (pending_q[i] && (2'(i) > floor_q)) above = 1'b1;
         if (pending_q[i] && (2'(i) < floor_q)) below = 1'b1;
      end

      // Keep going the current way while work remains there, otherwise prefer down.
      if (dir_q && above)  sel_state = S_MOVE_UP;
      else if (below)      sel_state = S_MOVE_DOWN;
      else if (above)      sel_state = S_MOVE_UP;
      else                 sel_state = S_IDLE;

      case (state_q)
         S_IDLE: state_d = pending_q[floor_q] ? S_DOOR : sel_state;
         S_MOVE_UP: begin
            if (travel_done) begin
               arrive  = 1'b1;
               floor_d = floor_up;
               if (pending_q[floor_up]) state_d = S_DOOR;
            end
         end
         S_MOVE_DOWN: begin
            if (travel_done) begin
               arrive  = 1'b1;
               floor_d = floor_dn;
               if (pending_q[floor_dn]) state_d = S_DOOR;
            end
         end
         S_DOOR: if (door_done) state_d = sel_state;
         default: state_d = S_IDLE;
      endcase

      if ((state_d != state_q) || arrive || (state_q == S_IDLE)) cnt_d = 16'd0;
      else                                                       cnt_d = cnt_q + 16'd1;

      if (state_d == S_MOVE_UP)        dir_d = 1'b1;
      else if (state_d == S_MOVE_DOWN) dir_d = 1'b0;
      else                             dir_d = dir_q;

      // A call for the floor whose door is already open is simply ignored.
      drop_mask = (state_q == S_DOOR) ? (4'b0001 << floor_q) : 4'b0000;
      clr_mask  = ((state_d == S_DOOR) && (state_q != S_DOOR)) ? (4'b0001 << floor_d) : 4'b0000;
      pending_d = (pending_q | (call_req & ~drop_mask)) & ~clr_mask;
   end

   assign floor      = floor_q;
   assign pending    = pending_q;
   assign motor_up   = (state_q == S_MOVE_UP);
   assign motor_down = (state_q == S_MOVE_DOWN);
   assign door_open  = (state_q == S_DOOR);
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_crazy_elevator_ctrl.sv
// tb/tb_crazy_elevator_ctrl.sv - directed self-checking bench for crazy_elevator_ctrl
// Observation word is {floor, motor_up, motor_down, door_open, busy, pending}.
module tb_crazy_elevator_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] call_req = 4'b0000;
   logic [1:0] floor;
   logic       motor_up, motor_down, door_open, busy;
   logic [3:0] pending;
   logic [9:0] obs;
   int         n_checks = 0;
   int         n_pass = 0;

   crazy_elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .call_req  (call_req),
      .floor     (floor),
      .motor_up  (motor_up),
      .motor_down(motor_down),
      .door_open (door_open),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   assign obs = {floor, motor_up, motor_down, door_open, busy, pending};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] c);
      call_req = c;
      tick();
      call_req = 4'b0000;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if (obs !== 10'b00_0000_0000) $display("FAIL reset_async got %b expected %b", obs, 10'b00_0000_0000);
      else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (obs !== 10'b00_0000_0000) $display("FAIL reset_release got %b expected %b", obs, 10'b00_0000_0000);
      else n_pass++;
   endtask

   task automatic test_up_trip();
      logic [9:0] sv [4] = '{{2'd0,4'b1001,4'b0100}, {2'd1,4'b1001,4'b0100},
                             {2'd2,4'b0011,4'b0000}, {2'd2,4'b0000,4'b0000}};
      int         sn [4] = '{4, 4, 3, 2};
      int         step = 0;
      pulse(4'b0100);
      n_checks++;
      if (obs !== {2'd0,4'b0000,4'b0100}) $display("FAIL up_trip_latch got %b expected %b", obs, {2'd0,4'b0000,4'b0100});
      else n_pass++;
      for (int s = 0; s < 4; s++) begin
         for (int r = 0; r < sn[s]; r++) begin
            tick();
            step++;
            n_checks++;
            if (obs !== sv[s]) $display("FAIL up_trip edge k+%0d got %b expected %b", step, obs, sv[s]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_split_calls();
      logic [9:0] sv [7] = '{{2'd2,4'b1001,4'b1001}, {2'd3,4'b0011,4'b0001}, {2'd3,4'b0101,4'b0001},
                             {2'd2,4'b0101,4'b0001}, {2'd1,4'b0101,4'b0001}, {2'd0,4'b0011,4'b0000},
                             {2'd0,4'b0000,4'b0000}};
      int         sn [7] = '{4, 3, 4, 4, 4, 3, 2};
      int         step = 0;
      pulse(4'b1001);
      n_checks++;
      if (obs !== {2'd2,4'b0000,4'b1001}) $display("FAIL split_latch got %b expected %b", obs, {2'd2,4'b0000,4'b1001});
      else n_pass++;
      for (int s = 0; s < 7; s++) begin
         for (int r = 0; r < sn[s]; r++) begin
            tick();
            step++;
            n_checks++;
            if (obs !== sv[s]) $display("FAIL split_calls edge k+%0d got %b expected %b", step, obs, sv[s]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_same_floor();
      logic [9:0] sv [2] = '{{2'd1,4'b0011,4'b0000}, {2'd1,4'b0000,4'b0000}};
      int         sn [2] = '{3, 2};
      int         step = 0;
      pulse(4'b0010);
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if (obs !== {2'd1,4'b0000,4'b0000}) $display("FAIL same_floor_setup got %b expected %b", obs, {2'd1,4'b0000,4'b0000});
      else n_pass++;
      pulse(4'b0010);
      n_checks++;
      if (obs !== {2'd1,4'b0000,4'b0010}) $display("FAIL same_floor_latch got %b expected %b", obs, {2'd1,4'b0000,4'b0010});
      else n_pass++;
      for (int s = 0; s < 2; s++) begin
         for (int r = 0; r < sn[s]; r++) begin
            tick();
            step++;
            n_checks++;
            if (obs !== sv[s]) $display("FAIL same_floor edge k+%0d got %b expected %b", step, obs, sv[s]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_door_call();
      logic [9:0] sv [5] = '{{2'd1,4'b0011,4'b0000}, {2'd1,4'b0011,4'b0000}, {2'd1,4'b0011,4'b0000},
                             {2'd1,4'b0000,4'b0000}, {2'd1,4'b0000,4'b0000}};
      pulse(4'b0010);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) pulse(4'b0010);
         else tick();
         n_checks++;
         if (obs !== sv[i]) $display("FAIL door_call edge k+%0d got %b expected %b", i + 1, obs, sv[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reversal();
      logic [9:0] sv [8] = '{{2'd1,4'b1001,4'b1001}, {2'd2,4'b1001,4'b1001}, {2'd3,4'b0011,4'b0001},
                             {2'd3,4'b0101,4'b0001}, {2'd2,4'b0101,4'b0001}, {2'd1,4'b0101,4'b0001},
                             {2'd0,4'b0011,4'b0000}, {2'd0,4'b0000,4'b0000}};
      int         sn [8] = '{1, 4, 3, 4, 4, 4, 3, 1};
      int         step = 3;
      pulse(4'b1000);
      tick();
      n_checks++;
      if (obs !== {2'd1,4'b1001,4'b1000}) $display("FAIL reversal_start got %b expected %b", obs, {2'd1,4'b1001,4'b1000});
      else n_pass++;
      tick();
      pulse(4'b0001);
      n_checks++;
      if (obs !== {2'd1,4'b1001,4'b1001}) $display("FAIL reversal_latch got %b expected %b", obs, {2'd1,4'b1001,4'b1001});
      else n_pass++;
      for (int s = 0; s < 8; s++) begin
         for (int r = 0; r < sn[s]; r++) begin
            tick();
            step++;
            n_checks++;
            if (obs !== sv[s]) $display("FAIL reversal edge k+%0d got %b expected %b", step, obs, sv[s]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_move();
      pulse(4'b1000);
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (obs !== {2'd0,4'b1001,4'b1000}) $display("FAIL midmove_before got %b expected %b", obs, {2'd0,4'b1001,4'b1000});
      else n_pass++;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (obs !== 10'b00_0000_0000) $display("FAIL midmove_async got %b expected %b", obs, 10'b00_0000_0000);
      else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (obs !== 10'b00_0000_0000) $display("FAIL midmove_after edge %0d got %b expected %b", i, obs, 10'b00_0000_0000);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_up_trip();
      test_split_calls();
      test_same_floor();
      test_door_call();
      test_reversal();
      test_reset_mid_move();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/crazy_elevator_ctrl.md
CRAZY_ELEVATOR_CTRL -- requirements
Module: crazy_elevator_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8: clock cycles spent moving between adjacent floors; legal range 1..65535.
REQ-002 Parameter DOOR_CYCLES, default 6: clock cycles the door stays open per stop; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 call_req  input  4  per-floor call; bit i high for a cycle requests floor i; multiple bits may be high together.
REQ-006 floor  output  2  current floor, 0..3, registered.
REQ-007 motor_up  output  1  high exactly while state is MOVE_UP.
REQ-008 motor_down  output  1  high exactly while state is MOVE_DOWN.
REQ-009 door_open  output  1  high exactly while state is DOOR.
REQ-010 pending  output  4  registered outstanding-call vector.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM shall have four states: IDLE, MOVE_UP, MOVE_DOWN, DOOR; motor_up, motor_down and door_open shall be one-hot or all zero.
REQ-013 Each edge shall set pending[i] for every high call_req[i], except bit floor while in DOOR, which is dropped and not latched.
REQ-014 pending[floor] shall be cleared on the edge that enters DOOR; no other event clears pending except reset.
REQ-015 Direction register dir (1 = up) shall update to 1 on entering MOVE_UP and to 0 on entering MOVE_DOWN.
REQ-016 above/below = any pending bit strictly above/below floor, from unsigned 2-bit compare of the bit index against floor.
REQ-017 Decisions in IDLE and at DOOR expiry shall use the registered pending vector, so a call sampled at edge k acts at edge k+1 at the earliest.
REQ-018 IDLE priority: pending[floor] -> DOOR; else dir=1 and above -> MOVE_UP; else below -> MOVE_DOWN; else above -> MOVE_UP; else stay IDLE.
REQ-019 A 16-bit cycle counter shall zero on every state entry and increment each cycle in MOVE_x and DOOR.
REQ-020 In MOVE_UP/MOVE_DOWN, the edge where counter == TRAVEL_CYCLES-1 shall step floor by +1/-1.
REQ-021 On that edge, if pending[new floor] is set, the FSM shall enter DOOR; else it shall stay in the same move state with counter zeroed.
REQ-022 In DOOR, the edge where counter == DOOR_CYCLES-1 shall apply the REQ-018 selection, excluding the pending[floor] term, and choose MOVE_UP, MOVE_DOWN or IDLE.
REQ-023 floor shall never wrap: MOVE_UP shall not be entered at floor 3, and MOVE_DOWN shall not be entered at floor 0.
REQ-024 Calls arriving during MOVE_x for floors behind the car shall be latched and served after reversal per REQ-022.

Reset
REQ-025 While rst_n is low, regardless of clk: state IDLE, floor 0, pending 0, dir 1, counter 0, motor_up 0, motor_down 0, door_open 0, busy 0.
REQ-026 Reset asserted mid-move or mid-door shall abandon the operation, discard all pending calls and hold the reset values until the first edge after release.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Idle at floor 0, call_req=0100 sampled at edge k -> pending=0100 after k, motor_up after k+1, floor=1 after k+5, floor=2, door_open=1 and pending=0000 after k+9, door_open for 3 cycles, then IDLE with busy=0.
REQ-028 Idle at floor 1, call_req=0010 -> DOOR one edge after pending sets, motor never asserted, pending returns to 0000.
REQ-029 Car at floor 1 moving up toward 3; call_req=0001 mid-travel -> car stops at 3, then after door closes runs MOVE_DOWN to floor 0; pending bit 0 stays set until the floor-0 arrival.
REQ-030 Idle at floor 2 with dir=1, call_req=1001 in one cycle -> serves floor 3 first, then floor 0; floor never exceeds 3 or goes below 0.
REQ-031 call_req for the current floor during DOOR -> not latched; pending unchanged; door time not extended.
REQ-032 rst_n pulsed low mid-MOVE_UP with pending=1000 -> outputs immediately take the REQ-025 values; after release, the FSM stays IDLE with no motion.
